// File: rtl/ram_pingpong_wr_pkg.sv
// Shared sizes, FSM encodings and the byte-length to word-count helper
// for the ping-pong packet buffer.
package ram_pingpong_wr_pkg;
  localparam int DW         = 32;
  localparam int AW         = 9;
  localparam int BANK_WORDS = 512;

  typedef enum logic {W_FILL = 1'b0, W_BLOCK = 1'b1} wr_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_BUSY  = 1'b1} rd_state_t;

  // Round bytes up to whole words and clamp to one bank.
  function automatic logic [9:0] exp_words(input logic [15:0] len);
    logic [16:0] w;
    w = ({1'b0, len} + 17'd3) >> 2;
    if (w > 17'(BANK_WORDS)) return 10'(BANK_WORDS);
    return w[9:0];
  endfunction
endpackage

// File: rtl/ram_pingpong_wr_dpram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Only the read register is cleared; array contents survive resets.
module dpram_1024x32 #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   rdata <= '0;
    else if (clr) rdata <= '0;
    else          rdata <= mem[raddr];
endmodule

// File: rtl/ram_pingpong_wr.sv
// Two-bank packet buffer: the write side fills banks alternately, the read
// side offers completed banks to a consumer in arrival order.
module ram_pingpong_wr #(
  parameter int DW = ram_pingpong_wr_pkg::DW,
  parameter int AW = ram_pingpong_wr_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] rx_data,
  input  logic [AW-1:0] ram_wr_ddr,
  input  logic          data_o_valid,
  input  logic [15:0]   data_o_length,
  input  logic          soft_reset,
  output logic          buf_ready,
  output logic          buf_bank,
  output logic [9:0]    buf_words,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          buf_done,
  output logic          overflow
);
  import ram_pingpong_wr_pkg::*;

  wr_state_t       wstate;
  rd_state_t       rstate;
  logic            wbank, nbank, rd_ptr;
  logic [9:0]      wcnt, wcnt_inc, exp_w;
  logic [1:0]      full;
  logic [1:0][9:0] bank_cnt;
  logic            word_in, wr_en, pkt_end, fill_done, rel, nbank_free;

  assign exp_w      = exp_words(data_o_length);
  assign wcnt_inc   = wcnt + 10'd1;
  assign nbank      = ~wbank;
  assign word_in    = data_o_valid && (exp_w != 10'd0);
  assign wr_en      = word_in && (wstate == W_FILL);
  assign pkt_end    = word_in && (wcnt_inc == exp_w);
  assign fill_done  = wr_en && (wcnt_inc == exp_w);
  assign rel        = (rstate == R_BUSY) && buf_done;
  // A bank released in the same cycle counts as free.
  assign nbank_free = !full[nbank] || (rel && (buf_bank == nbank));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full     <= '0;
      bank_cnt <= '0;
    end else if (soft_reset) begin
      full     <= '0;
      bank_cnt <= '0;
    end else begin
      if (rel) full[buf_bank] <= 1'b0;
      if (fill_done) begin
        full[wbank]     <= 1'b1;
        bank_cnt[wbank] <= exp_w;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wstate   <= W_FILL;
      wbank    <= 1'b0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else if (soft_reset) begin
      wstate   <= W_FILL;
      wbank    <= 1'b0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      case (wstate)
        W_FILL:
          if (word_in) begin
            if (pkt_end) begin
              wcnt  <= '0;
              wbank <= nbank;
              if (!nbank_free) wstate <= W_BLOCK;
            end else begin
              wcnt <= wcnt_inc;
            end
          end
        W_BLOCK: begin
          // Keep counting dropped words so the next packet starts aligned.
          if (word_in) begin
            overflow <= 1'b1;
            wcnt     <= pkt_end ? 10'd0 : wcnt_inc;
          end
          if (rel && (buf_bank == wbank)) wstate <= W_FILL;
        end
        default: wstate <= W_FILL;
      endcase
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rstate    <= R_IDLE;
      buf_ready <= 1'b0;
      buf_bank  <= 1'b0;
      buf_words <= '0;
      rd_ptr    <= 1'b0;
    end else if (soft_reset) begin
      rstate    <= R_IDLE;
      buf_ready <= 1'b0;
      buf_bank  <= 1'b0;
      buf_words <= '0;
      rd_ptr    <= 1'b0;
    end else begin
      case (rstate)
        R_IDLE:
          // Banks complete alternately, so rd_ptr names the older one.
          if (full[rd_ptr]) begin
            rstate    <= R_BUSY;
            buf_ready <= 1'b1;
            buf_bank  <= rd_ptr;
            buf_words <= bank_cnt[rd_ptr];
          end else if (full[~rd_ptr]) begin
            rstate    <= R_BUSY;
            buf_ready <= 1'b1;
            buf_bank  <= ~rd_ptr;
            buf_words <= bank_cnt[~rd_ptr];
          end
        R_BUSY:
          if (buf_done) begin
            rstate    <= R_IDLE;
            buf_ready <= 1'b0;
            rd_ptr    <= ~buf_bank;
          end
        default: rstate <= R_IDLE;
      endcase
    end

  dpram_1024x32 #(.DW(DW), .AW(AW+1)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_reset),
    .we    (wr_en),
    .waddr ({wbank, ram_wr_ddr}),
    .wdata (rx_data),
    .raddr ({buf_bank, rd_addr}),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_ram_pingpong_wr.sv
// Directed bench for ram_pingpong_wr: stimulus queues expected offers,
// a monitor pops them on each buf_ready rise and reads the bank back.
module tb_ram_pingpong_wr;
  localparam int DW = 32;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] rx_data;
  logic [AW-1:0] ram_wr_ddr;
  logic          data_o_valid;
  logic [15:0]   data_o_length;
  logic          soft_reset;
  logic          buf_ready;
  logic          buf_bank;
  logic [9:0]    buf_words;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          buf_done;
  logic          overflow;

  always #5 clk = ~clk;

  ram_pingpong_wr #(.DW(DW), .AW(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_data       (rx_data),
    .ram_wr_ddr    (ram_wr_ddr),
    .data_o_valid  (data_o_valid),
    .data_o_length (data_o_length),
    .soft_reset    (soft_reset),
    .buf_ready     (buf_ready),
    .buf_bank      (buf_bank),
    .buf_words     (buf_words),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .buf_done      (buf_done),
    .overflow      (overflow)
  );

  typedef struct {logic bank; int words;} offer_t;
  offer_t        exp_q[$];
  logic [DW-1:0] exp_mem [2][512];
  int n_chk = 0, n_pass = 0, mon_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int id, input int a);
    return 32'hC300_0000 ^ {16'(id), 16'(a)};
  endfunction

  task automatic send_pkt(input int len, input int nw, input int id, input logic bank,
                          input bit accept, input bit done_last);
    if (accept) exp_q.push_back('{bank, nw});
    data_o_length = 16'(len);
    for (int i = 0; i < nw; i++) begin
      tick();
      data_o_valid = 1'b1;
      ram_wr_ddr   = AW'(i);
      rx_data      = pat(id, i);
      buf_done     = done_last && (i == nw - 1);
      if (accept) exp_mem[bank][i] = rx_data;
    end
    tick();
    data_o_valid = 1'b0;
    buf_done     = 1'b0;
  endtask

  task automatic wait_mon(input int n);
    int t = 0;
    while (mon_seen < n && t < 3000) begin
      tick();
      t++;
    end
    n_chk++;
    if (mon_seen >= n) n_pass++;
    else $display("FAIL wait_offer: seen %0d required %0d", mon_seen, n);
  endtask

  task automatic pulse_done();
    check("ready_before_done", buf_ready, 1);
    tick();
    buf_done = 1'b1;
    tick();
    buf_done = 1'b0;
    check("ready_after_done", buf_ready, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: owns rd_addr, compares each new offer and its contents.
  initial begin : monitor
    logic prev, ok;
    offer_t e;
    int bad_a;
    logic [DW-1:0] bad_v;
    prev = 1'b0;
    rd_addr = '0;
    forever begin
      @(negedge clk);
      if (buf_ready && !prev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_offer: bank %0d words %0d, none required", buf_bank, buf_words);
        end else begin
          e = exp_q.pop_front();
          check("offer_bank", 32'(buf_bank), 32'(e.bank));
          check("offer_words", 32'(buf_words), e.words);
          ok = 1'b1;
          bad_a = 0;
          bad_v = '0;
          for (int a = 0; a < e.words; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            if (ok && rd_data !== exp_mem[e.bank][a]) begin
              ok = 1'b0;
              bad_a = a;
              bad_v = rd_data;
            end
          end
          n_chk++;
          if (ok) n_pass++;
          else $display("FAIL readback: bank %0d addr %0d got %0h expected %0h",
                        e.bank, bad_a, bad_v, exp_mem[e.bank][bad_a]);
        end
        mon_seen++;
      end
      prev = buf_ready;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int m0;
    rst_n = 1'b0; rx_data = '0; ram_wr_ddr = '0; data_o_valid = 1'b0;
    data_o_length = '0; soft_reset = 1'b0; buf_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", buf_ready, 0);
    check("rst_bank", buf_bank, 0);
    check("rst_words", buf_words, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;

    // 16-word packet, readback, release
    m0 = mon_seen;
    send_pkt(64, 16, 1, 1'b0, 1, 0);
    wait_mon(m0 + 1);
    pulse_done();
    check("t1_queue", exp_q.size(), 0);

    // 2-word then full 512-word packet, offered in order
    do_reset();
    m0 = mon_seen;
    send_pkt(6, 2, 2, 1'b0, 1, 0);
    send_pkt(2048, 512, 3, 1'b1, 1, 0);
    wait_mon(m0 + 1);
    pulse_done();
    wait_mon(m0 + 2);
    pulse_done();
    check("t2_overflow", overflow, 0);
    check("t2_queue", exp_q.size(), 0);

    // release coinciding with the last word of the other bank
    do_reset();
    m0 = mon_seen;
    send_pkt(16, 4, 4, 1'b0, 1, 0);
    wait_mon(m0 + 1);
    send_pkt(16, 4, 5, 1'b1, 1, 1);
    send_pkt(16, 4, 6, 1'b0, 1, 0);
    check("t3_overflow_mid", overflow, 0);
    wait_mon(m0 + 2);
    pulse_done();
    wait_mon(m0 + 3);
    check("t3_overflow", overflow, 0);
    pulse_done();
    check("t3_queue", exp_q.size(), 0);

    // third packet dropped, fourth lands in bank 0
    do_reset();
    m0 = mon_seen;
    send_pkt(32, 8, 7, 1'b0, 1, 0);
    send_pkt(32, 8, 8, 1'b1, 1, 0);
    send_pkt(32, 8, 9, 1'b0, 0, 0);
    check("t4_overflow", overflow, 1);
    wait_mon(m0 + 1);
    pulse_done();
    wait_mon(m0 + 2);
    pulse_done();
    send_pkt(32, 8, 10, 1'b0, 1, 0);
    wait_mon(m0 + 3);
    check("t4_overflow_sticky", overflow, 1);
    check("t4_queue", exp_q.size(), 0);

    // hard reset mid-packet while an offer and overflow are pending
    m0 = mon_seen;
    send_pkt(40, 5, 11, 1'b1, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_ready", buf_ready, 0);
    check("t5_bank", buf_bank, 0);
    check("t5_words", buf_words, 0);
    check("t5_overflow", overflow, 0);
    check("t5_rd_data", rd_data, 0);
    tick();
    rst_n = 1'b1;
    send_pkt(40, 10, 12, 1'b0, 1, 0);
    wait_mon(m0 + 1);
    check("t5_queue", exp_q.size(), 0);

    // soft reset clears the pending offer
    tick();
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    check("sr_ready", buf_ready, 0);
    check("sr_words", buf_words, 0);
    check("sr_rd_data", rd_data, 0);

    // zero length writes nothing; next 1-word packet starts clean in bank 0
    m0 = mon_seen;
    send_pkt(0, 5, 13, 1'b0, 0, 0);
    repeat (10) tick();
    check("t6_ready", buf_ready, 0);
    check("t6_overflow", overflow, 0);
    check("t6_no_offer", mon_seen, m0);
    send_pkt(3, 1, 14, 1'b0, 1, 0);
    wait_mon(m0 + 1);
    pulse_done();
    check("t6_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
